// File: rtl/longest_run_detector.sv
`default_nettype none
// ============================================================================
// Module      : longest_run_detector
// Description : Streaming longest-run-of-identical-bits detector over framed
//               words (MSB first), with polarity select, start index,
//               saturation flag and frame-done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module longest_run_detector #(
    parameter int DIN_W = 3,
    parameter int LEN_W = 4,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             count,
    input  logic             pol,
    input  logic [DIN_W-1:0] din,
    output logic [LEN_W-1:0] length,
    output logic [LEN_W-1:0] cur_run,
    output logic [IDX_W-1:0] start_idx,
    output logic             sat,
    output logic             done
);

    localparam logic [LEN_W-1:0] c_RUN_MAX = '1;
    localparam logic [IDX_W-1:0] c_BIDX_STEP = IDX_W'(DIN_W);

    logic             r_act;
    logic             r_pol;
    logic [LEN_W-1:0] r_run;
    logic [LEN_W-1:0] r_max;
    logic [IDX_W-1:0] r_bidx;
    logic [IDX_W-1:0] r_run_start;
    logic [IDX_W-1:0] r_max_start;
    logic             r_sat;
    logic             r_done;

    logic             w_frame_start;
    logic             w_pol;
    logic [LEN_W-1:0] w_run;
    logic [LEN_W-1:0] w_max;
    logic [IDX_W-1:0] w_bidx;
    logic [IDX_W-1:0] w_run_start;
    logic [IDX_W-1:0] w_max_start;
    logic             w_sat;

    assign w_frame_start = count && !r_act;

    // Walk the word bit by bit starting from a cleared context on frame start.
    always_comb begin
        w_pol       = w_frame_start ? pol : r_pol;
        w_run       = w_frame_start ? '0 : r_run;
        w_max       = w_frame_start ? '0 : r_max;
        w_bidx      = w_frame_start ? '0 : r_bidx;
        w_run_start = w_frame_start ? '0 : r_run_start;
        w_max_start = w_frame_start ? '0 : r_max_start;
        w_sat       = w_frame_start ? 1'b0 : r_sat;
        for (int j = 0; j < DIN_W; j++) begin
            if (din[DIN_W-1-j] == w_pol) begin
                if (w_run == '0) begin
                    w_run_start = w_bidx + IDX_W'(j);
                end
                if (w_run != c_RUN_MAX) begin
                    w_run = w_run + LEN_W'(1);
                end
                if (w_run == c_RUN_MAX) begin
                    w_sat = 1'b1;
                end
            end else begin
                w_run = '0;
            end
            if (w_run > w_max) begin
                w_max       = w_run;
                w_max_start = w_run_start;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_act       <= 1'b0;
            r_pol       <= 1'b0;
            r_run       <= '0;
            r_max       <= '0;
            r_bidx      <= '0;
            r_run_start <= '0;
            r_max_start <= '0;
            r_sat       <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (count) begin
                r_act       <= 1'b1;
                r_pol       <= w_pol;
                r_run       <= w_run;
                r_max       <= w_max;
                r_bidx      <= w_bidx + c_BIDX_STEP;
                r_run_start <= w_run_start;
                r_max_start <= w_max_start;
                r_sat       <= w_sat;
            end else if (r_act) begin
                r_act  <= 1'b0;
                r_done <= 1'b1;
            end
        end
    end

    assign length    = r_max;
    assign cur_run   = r_run;
    assign start_idx = r_max_start;
    assign sat       = r_sat;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_longest_run_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_longest_run_detector
// Description : Scoreboard bench; a frame-history reference model queues the
//               expected outputs, a monitor compares them after each posedge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_longest_run_detector;

    localparam int DIN_W = 3;
    localparam int LEN_W = 4;
    localparam int IDX_W = 8;
    localparam int MAXV  = (1 << LEN_W) - 1;

    logic             clk;
    logic             rst;
    logic             count;
    logic             pol;
    logic [DIN_W-1:0] din;
    logic [LEN_W-1:0] length;
    logic [LEN_W-1:0] cur_run;
    logic [IDX_W-1:0] start_idx;
    logic             sat;
    logic             done;

    longest_run_detector #(.DIN_W(DIN_W), .LEN_W(LEN_W), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .count(count), .pol(pol), .din(din),
        .length(length), .cur_run(cur_run), .start_idx(start_idx),
        .sat(sat), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int length;
        int cur_run;
        int start_idx;
        int sat;
        int done;
    } exp_t;

    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    // Reference model: keeps the whole frame's bits and re-derives results.
    bit   m_act;
    bit   m_pol;
    bit   m_bits[$];
    exp_t m_out;

    function automatic void recompute();
        int best, bstart, rlen, rstart, trail;
        bit any_sat;
        best = 0; bstart = 0; any_sat = 0; rlen = 0; rstart = 0;
        for (int i = 0; i <= m_bits.size(); i++) begin
            if (i < m_bits.size() && m_bits[i] == m_pol) begin
                if (rlen == 0) rstart = i;
                rlen++;
            end else begin
                if (rlen > 0) begin
                    if ((rlen < MAXV ? rlen : MAXV) > best) begin
                        best   = (rlen < MAXV ? rlen : MAXV);
                        bstart = rstart;
                    end
                    if (rlen >= MAXV) any_sat = 1;
                end
                trail = rlen;
                rlen  = 0;
            end
        end
        // trail holds the run closed by the end-of-frame sentinel
        m_out.length    = best;
        m_out.start_idx = bstart % (1 << IDX_W);
        m_out.cur_run   = (trail < MAXV) ? trail : MAXV;
        m_out.sat       = any_sat;
    endfunction

    task automatic step(input bit c, input bit [DIN_W-1:0] d, input bit p, input bit r);
        @(negedge clk);
        count = c; din = d; pol = p; rst = r;
        m_out.done = 0;
        if (r) begin
            m_act = 0;
            m_bits.delete();
            m_out = '{0, 0, 0, 0, 0};
        end else if (c) begin
            if (!m_act) begin
                m_act = 1;
                m_pol = p;
                m_bits.delete();
            end
            for (int k = DIN_W - 1; k >= 0; k--) m_bits.push_back(d[k]);
            recompute();
        end else if (m_act) begin
            m_act      = 0;
            m_out.done = 1;
        end
        exp_q.push_back(m_out);
    endtask

    task automatic chk(input string name, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("length",    int'(length),    e.length);
            chk("cur_run",   int'(cur_run),   e.cur_run);
            chk("start_idx", int'(start_idx), e.start_idx);
            chk("sat",       int'(sat),       e.sat);
            chk("done",      int'(done),      e.done);
        end
    end

    initial begin
        int nw;
        bit p;
        bit [DIN_W-1:0] w;
        rst = 1'b1; count = 1'b0; pol = 1'b0; din = '0;
        m_act = 0; m_pol = 0; m_out = '{0, 0, 0, 0, 0};
        step(0, 3'b000, 0, 1);
        step(0, 3'b000, 0, 1);
        // basic ones run, then held idle
        step(1, 3'b110, 1, 0); step(1, 3'b111, 1, 0); step(1, 3'b011, 1, 0);
        step(0, 3'b000, 1, 0); step(0, 3'b000, 0, 0);
        // zero polarity, pol change mid-frame ignored
        step(1, 3'b000, 0, 0); step(1, 3'b001, 1, 0); step(0, 3'b000, 0, 0);
        // tie and cross-word run
        step(1, 3'b110, 1, 0); step(1, 3'b110, 1, 0); step(0, 3'b000, 1, 0);
        step(1, 3'b011, 1, 0); step(1, 3'b100, 1, 0); step(0, 3'b000, 1, 0);
        // saturation
        repeat (6) step(1, 3'b111, 1, 0);
        step(0, 3'b000, 1, 0);
        // reset mid-frame, reset with count=1 loses the frame start
        step(1, 3'b111, 1, 0); step(1, 3'b111, 1, 0);
        step(1, 3'b111, 1, 1);
        step(1, 3'b101, 1, 0); step(0, 3'b000, 1, 0);
        // back-to-back frames with a single idle cycle
        step(1, 3'b111, 1, 0); step(1, 3'b111, 1, 0); step(0, 3'b000, 1, 0);
        step(1, 3'b010, 1, 0); step(0, 3'b000, 1, 0);
        // randomized frames, some long enough to wrap the bit index
        for (int f = 0; f < 60; f++) begin
            p  = 1'($urandom_range(0, 1));
            nw = ($urandom_range(0, 7) == 0) ? $urandom_range(86, 100) : $urandom_range(1, 12);
            for (int i = 0; i < nw; i++) begin
                w = DIN_W'($urandom_range(0, 7));
                if ($urandom_range(0, 1) == 1) w = p ? '1 : '0;
                step(1, w, ($urandom_range(0, 3) == 0) ? ~p : p,
                     ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
            end
            repeat ($urandom_range(1, 3)) step(0, DIN_W'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 0);
        end
        step(0, 3'b000, 0, 0);
        for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
